// File: rtl/pixel_plot_writer.sv
// Rasterizer pixel sink: clips, buffers and writes pixels to a framebuffer port as y*SCR_W+x.
// Optional PLOT_DEDUP_EN drops an in-screen pixel repeating the previous accepted in-screen (x,y).
module pixel_plot_writer #(
  parameter int unsigned SCR_W      = 200,
  parameter int unsigned SCR_H      = 120,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned COLOR_W    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic signed [8:0]  pix_x,
  input  logic signed [7:0]  pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               gen_done,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_wdata,
  input  logic               fb_ack,
  output logic [15:0]        clip_cnt,
  output logic               plot_done,
  output logic               busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e state_q, state_d;

  logic [PtrW:0]        wr_ptr_q, rd_ptr_q;
  logic [8:0]           mem_x [FIFO_DEPTH];
  logic [7:0]           mem_y [FIFO_DEPTH];
  logic [COLOR_W-1:0]   mem_c [FIFO_DEPTH];
  logic                 fifo_full, fifo_empty;
  logic                 accept, on_screen, dup, push, pop;
  logic                 new_frame;
  int                   x_s, y_s;
  logic [ADDR_W-1:0]    head_addr;
  logic                 fb_we_d;
  logic [ADDR_W-1:0]    fb_addr_d;
  logic [COLOR_W-1:0]   fb_wdata_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign pix_ready = !fifo_full && (state_q != StDone);
  assign accept    = pix_valid && pix_ready;

  assign x_s       = int'(pix_x);
  assign y_s       = int'(pix_y);
  assign on_screen = (x_s >= 0) && (x_s < int'(SCR_W)) && (y_s >= 0) && (y_s < int'(SCR_H));
  assign push      = accept && on_screen && !dup;

  assign new_frame = (state_q == StDone) && !gen_done;

`ifdef PLOT_DEDUP_EN
  logic       last_valid_q;
  logic [8:0] last_x_q;
  logic [7:0] last_y_q;

  assign dup = last_valid_q && (last_x_q == pix_x) && (last_y_q == pix_y);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_valid_q <= 1'b0;
      last_x_q     <= '0;
      last_y_q     <= '0;
    end else if (new_frame) begin
      last_valid_q <= 1'b0;
    end else if (accept && on_screen) begin
      last_valid_q <= 1'b1;
      last_x_q     <= pix_x;
      last_y_q     <= pix_y;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Coordinates are non-negative once stored, so the unsigned widening is exact.
  assign head_addr = ADDR_W'(mem_y[rd_ptr_q[PtrW-1:0]]) * ADDR_W'(SCR_W)
                   + ADDR_W'(mem_x[rd_ptr_q[PtrW-1:0]]);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr_q[PtrW-1:0]] <= pix_x;
      mem_y[wr_ptr_q[PtrW-1:0]] <= pix_y;
      mem_c[wr_ptr_q[PtrW-1:0]] <= pix_color;
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    fb_we_d    = fb_we;
    fb_addr_d  = fb_addr;
    fb_wdata_d = fb_wdata;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          fb_we_d    = 1'b1;
          fb_addr_d  = head_addr;
          fb_wdata_d = mem_c[rd_ptr_q[PtrW-1:0]];
          state_d    = StWrite;
        end else if (gen_done && !pix_valid) begin
          state_d = StDone;
        end
      end
      StWrite: begin
        if (fb_ack) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            fb_addr_d  = head_addr;
            fb_wdata_d = mem_c[rd_ptr_q[PtrW-1:0]];
          end else begin
            fb_we_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      StDone: begin
        if (!gen_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
      clip_cnt <= '0;
    end else begin
      state_q  <= state_d;
      fb_we    <= fb_we_d;
      fb_addr  <= fb_addr_d;
      fb_wdata <= fb_wdata_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (new_frame) begin
        clip_cnt <= '0;
      end else if (accept && !on_screen && (clip_cnt != 16'hFFFF)) begin
        clip_cnt <= clip_cnt + 16'd1;
      end
    end
  end

  assign plot_done = (state_q == StDone);
  assign busy      = !fifo_empty || fb_we;

endmodule
